// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown sequencer: FSM state encoding
// and the load-value clamp.
package countdown_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] clamp(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low push-button to single-cycle press pulse: 2-flop synchroniser,
// stability counter and released->pressed edge detect.
module key_debounce #(
    parameter int DB_BITS = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic [1:0]         r_sync;
    logic [DB_BITS-1:0] r_cnt;
    logic               r_level;
    logic               r_press;
    logic               w_pressed;

    assign w_pressed = ~r_sync[1];

    // The level only flips after the synchronised key disagrees with it for
    // 2**DB_BITS consecutive cycles; any agreement restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (w_pressed == r_level) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_cnt   <= '0;
                r_level <= w_pressed;
                r_press <= w_pressed;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/countdown_ctrl.sv
// Button-driven countdown sequencer: debounced start/pause/load keys, FSM,
// run-gated tick prescaler and clamped count register feeding the display stages.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_BITS = 25,
    parameter int DB_BITS   = 16,
    parameter int START_VAL = 9,
    parameter int END_VAL   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_pause,
    input  logic             key_load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             done
);

    localparam logic [CNT_W-1:0] START_C = CNT_W'(START_VAL);
    localparam logic [CNT_W-1:0] END_C   = CNT_W'(END_VAL);

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_count, w_count_nxt;
    logic [TICK_BITS-1:0] r_pre, w_pre_nxt;
    logic                 r_tick, w_tick_nxt;
    logic                 r_done, w_done_nxt;

    logic w_press_start, w_press_pause, w_press_load;
    logic w_st, w_pa, w_ld;
    logic [CNT_W-1:0] w_load_clamped;

    key_debounce #(.DB_BITS(DB_BITS)) u_db_start (
        .i_clk(clk), .i_rst_n(rst), .i_key_n(key_start), .o_press(w_press_start)
    );
    key_debounce #(.DB_BITS(DB_BITS)) u_db_pause (
        .i_clk(clk), .i_rst_n(rst), .i_key_n(key_pause), .o_press(w_press_pause)
    );
    key_debounce #(.DB_BITS(DB_BITS)) u_db_load (
        .i_clk(clk), .i_rst_n(rst), .i_key_n(key_load), .o_press(w_press_load)
    );

    // Coincident presses: load wins over start, start over pause.
    assign w_ld = w_press_load;
    assign w_st = w_press_start & ~w_press_load;
    assign w_pa = w_press_pause & ~w_press_load & ~w_press_start;

    assign w_load_clamped = clamp(load_val, END_C, START_C);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_count <= START_C;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_pre   <= w_pre_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pre_nxt   = r_pre;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ld) begin
                    w_count_nxt = w_load_clamped;
                end else if (w_st) begin
                    w_state_nxt = ST_RUN;
                    w_pre_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (w_pa) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_pre_nxt = r_pre + 1'b1;
                    // A count already sitting at the terminal value finishes
                    // on its first wrap without decrementing.
                    if (&r_pre) begin
                        w_tick_nxt = 1'b1;
                        if (r_count > END_C) begin
                            w_count_nxt = r_count - 1'b1;
                            if (r_count == END_C + 1'b1) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (w_ld) begin
                    w_count_nxt = w_load_clamped;
                    w_state_nxt = ST_IDLE;
                end else if (w_st || w_pa) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_ld) begin
                    w_count_nxt = w_load_clamped;
                    w_state_nxt = ST_IDLE;
                end else if (w_st) begin
                    w_count_nxt = START_C;
                    w_pre_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (r_state == ST_RUN);
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign done  = r_done;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a short prescaler and debouncer.
module tb_countdown_ctrl;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_pause;
    logic       key_load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       running;
    logic       tick;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    countdown_ctrl #(
        .TICK_BITS(3), .DB_BITS(2), .START_VAL(9), .END_VAL(4)
    ) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_pause(key_pause), .key_load(key_load),
        .load_val(load_val),
        .count(count), .running(running), .tick(tick), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (tick === 1'b1) n_ticks++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] lv;
        logic [3:0] exp;
    } load_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_running(input logic lvl, input int bound, output int n, output logic found);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (running !== lvl && n < bound);
        found = (running === lvl);
    endtask

    task automatic wait_tick(input int bound, output int n, output logic found);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < bound);
        found = (tick === 1'b1);
    endtask

    task automatic wait_done(input int bound, output int n, output logic found);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < bound);
        found = (done === 1'b1);
    endtask

    initial begin
        load_vec_t vec [8];
        int         n, a, b, t0;
        logic       found, seen_run;
        logic [3:0] exp_down [5];

        vec[0] = '{4'd2,  4'd4};
        vec[1] = '{4'd13, 4'd9};
        vec[2] = '{4'd6,  4'd6};
        vec[3] = '{4'd4,  4'd4};
        vec[4] = '{4'd0,  4'd4};
        vec[5] = '{4'd15, 4'd9};
        vec[6] = '{4'd5,  4'd5};
        vec[7] = '{4'd7,  4'd7};
        exp_down[0] = 4'd8; exp_down[1] = 4'd7; exp_down[2] = 4'd6;
        exp_down[3] = 4'd5; exp_down[4] = 4'd4;

        rst = 1'b0; key_start = 1'b1; key_pause = 1'b1; key_load = 1'b1; load_val = 4'd0;

        // Reset held three cycles
        repeat (3) @(negedge clk);
        check("reset_count", count, 9);
        check("reset_running", running, 0);
        check("reset_tick", tick, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Start held 20 cycles: single pulse, full countdown to DONE
        key_start = 1'b0;
        fork
            begin
                repeat (20) @(negedge clk);
                key_start = 1'b1;
            end
        join_none
        wait_running(1'b1, 20, n, found);
        check("start_enters_run", found, 1);
        for (int i = 0; i < 5; i++) begin
            wait_tick(12, n, found);
            check("tick_period", n, 8);
            check("tick_count", count, exp_down[i]);
            if (i < 4) check("no_early_done", done, 0);
        end
        check("done_pulse", done, 1);
        check("done_state_not_running", running, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        t0 = n_ticks;
        repeat (40) @(negedge clk);
        check("no_ticks_in_done", n_ticks - t0, 0);
        check("done_count_holds", count, 4);

        // Restart from DONE, then pause/resume preserving prescaler phase
        key_start = 1'b0;
        wait_running(1'b1, 20, n, found);
        key_start = 1'b1;
        check("restart_from_done", found, 1);
        check("restart_count", count, 9);
        wait_tick(12, n, found);
        check("restart_tick1", count, 8);
        wait_tick(12, n, found);
        check("restart_tick2", count, 7);
        key_pause = 1'b0;
        wait_running(1'b0, 20, a, found);
        key_pause = 1'b1;
        check("pause_enters", found, 1);
        t0 = n_ticks;
        repeat (100) @(negedge clk);
        check("pause_count_holds", count, 7);
        check("pause_no_ticks", n_ticks - t0, 0);
        check("pause_not_running", running, 0);
        key_pause = 1'b0;
        wait_running(1'b1, 20, n, found);
        key_pause = 1'b1;
        check("resume_from_pause", found, 1);
        wait_tick(12, b, found);
        check("resume_phase_kept", a + b, 9);
        check("resume_tick_count", count, 6);
        wait_done(40, n, found);
        check("resume_reaches_done", found, 1);
        check("resume_done_count", count, 4);
        repeat (5) @(negedge clk);

        // Load clamping from DONE/IDLE
        foreach (vec[i]) begin
            load_val = vec[i].lv;
            key_load = 1'b0;
            repeat (10) @(negedge clk);
            key_load = 1'b1;
            repeat (10) @(negedge clk);
            check($sformatf("load_clamp_%0d", vec[i].lv), count, vec[i].exp);
            check("load_idle", running, 0);
        end

        // Load pressed during RUN is ignored
        key_start = 1'b0;
        wait_running(1'b1, 20, n, found);
        key_start = 1'b1;
        load_val = 4'd5;
        key_load = 1'b0;
        repeat (7) @(negedge clk);
        check("run_load_ignored_state", running, 1);
        check("run_load_ignored_count", count, 7);
        wait_tick(5, n, found);
        key_load = 1'b1;
        check("run_load_then_tick", count, 6);
        check("run_load_still_running", running, 1);
        key_pause = 1'b0;
        wait_running(1'b0, 20, n, found);
        key_pause = 1'b1;
        check("pause_before_combo", found, 1);
        repeat (10) @(negedge clk);

        // start+pause+load in the same cycle from PAUSE: load wins
        load_val = 4'd6;
        key_start = 1'b0; key_pause = 1'b0; key_load = 1'b0;
        repeat (10) @(negedge clk);
        key_start = 1'b1; key_pause = 1'b1; key_load = 1'b1;
        seen_run = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (running) seen_run = 1'b1;
        end
        check("combo_count", count, 6);
        check("combo_stays_idle", seen_run, 0);

        // Bouncing start key never registers
        key_start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            key_start = ~key_start;
        end
        key_start = 1'b1;
        seen_run = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (running) seen_run = 1'b1;
        end
        check("bounce_no_start", seen_run, 0);
        check("bounce_count", count, 6);

        // Reset mid-RUN
        key_start = 1'b0;
        wait_running(1'b1, 20, n, found);
        key_start = 1'b1;
        repeat (3) @(negedge clk);
        check("prereset_count", count, 6);
        check("prereset_running", running, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_count", count, 9);
        check("midrun_reset_running", running, 0);
        check("midrun_reset_tick", tick, 0);
        rst = 1'b1;
        seen_run = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (running) seen_run = 1'b1;
        end
        check("no_pulse_after_reset", seen_run, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
